branch_hazard_ctrl: RTL and testbench

- Stall/forward scheduler for the decode-stage branch comparator in the 5-stage MIPS pipeline.
- Keeps a shadow of in-flight destination registers and their Tnew counters for the E, M and W stages.
- Decides whether the D-stage instruction must stall, and which source the comparator's Rd1/Rd2 operands are forwarded from.
- Gates the comparator's Branch result so a branch is only taken when its operands are valid.

---
 rtl/branch_hazard_ctrl_if.sv | 32 +++
 rtl/branch_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// Decode-stage hazard bus: D-stage operand/destination info and the
// comparator branch decision flowing in, stall/forward controls flowing out.
interface branch_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] D_Rs;
  logic [REG_W-1:0] D_Rt;
  logic [T_W-1:0]   D_TuseRs;
  logic [T_W-1:0]   D_TuseRt;
  logic [REG_W-1:0] D_WriteReg;
  logic [T_W-1:0]   D_Tnew;
  logic             cmp_Branch;
  logic             stall;
  logic [1:0]       FwdRd1Sel;
  logic [1:0]       FwdRd2Sel;
  logic             take_branch;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: presents the D-stage instruction, consumes the controls.
  modport master (
    output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_WriteReg, D_Tnew, cmp_Branch,
    input  stall, FwdRd1Sel, FwdRd2Sel, take_branch, stall_cnt
  );

  // Scheduler side.
  modport slave (
    input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_WriteReg, D_Tnew, cmp_Branch,
    output stall, FwdRd1Sel, FwdRd2Sel, take_branch, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Stall/forward scheduler for the decode-stage branch comparator.
// Shadows the destination register and Tnew countdown of the instructions
// in E, M and W, stalls D while a needed operand is not yet forwardable,
// and picks the forwarding source for the comparator's two operands.
// stall, the selects and take_branch are combinational so they apply to
// the instruction currently sitting in D.
module branch_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_hazard_ctrl_if.slave bus
);

  localparam logic [T_W-1:0]   TUSE_NONE = {T_W{1'b1}};
  localparam logic [T_W-1:0]   TNEW_ZERO = {T_W{1'b0}};
  localparam logic [REG_W-1:0] REG_ZERO  = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_M  = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;

  // Shadow slots for the instructions in E, M and W.
  logic [REG_W-1:0] e_wreg_r, m_wreg_r, w_wreg_r;
  logic [T_W-1:0]   e_tnew_r, m_tnew_r, w_tnew_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic       stall_s;
  logic       hz_rs_s;
  logic       hz_rt_s;
  logic [1:0] fwd_rd1_s;
  logic [1:0] fwd_rd2_s;

  // Tnew countdown that bottoms out at zero once the value is forwardable.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    logic [T_W-1:0] r;
    if (x != TNEW_ZERO) begin
      r = x - {{(T_W-1){1'b0}}, 1'b1};
    end else begin
      r = TNEW_ZERO;
    end
    return r;
  endfunction

  // A source is hazardous when an in-flight producer in E or M will not have
  // its result ready by the time the consumer needs it. W is always ready.
  function automatic logic hazard(
    input logic [REG_W-1:0] src,
    input logic [T_W-1:0]   tuse,
    input logic [REG_W-1:0] e_wreg,
    input logic [T_W-1:0]   e_tnew,
    input logic [REG_W-1:0] m_wreg,
    input logic [T_W-1:0]   m_tnew
  );
    logic h;
    if ((tuse != TUSE_NONE) && (src != REG_ZERO)) begin
      h = ((e_wreg == src) && (e_tnew > tuse)) ||
          ((m_wreg == src) && (m_tnew > tuse));
    end else begin
      h = 1'b0;
    end
    return h;
  endfunction

  // Newest producer wins. A not-yet-ready newer producer blocks forwarding
  // from any older stage, so the comparator never sees a stale value.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] e_wreg,
    input logic [T_W-1:0]   e_tnew,
    input logic [REG_W-1:0] m_wreg,
    input logic [T_W-1:0]   m_tnew,
    input logic [REG_W-1:0] w_wreg,
    input logic [T_W-1:0]   w_tnew
  );
    logic [1:0] sel;
    if (src == REG_ZERO) begin
      sel = SEL_RF;
    end else if ((e_wreg == src) && (e_tnew != TNEW_ZERO)) begin
      sel = SEL_RF;
    end else if (m_wreg == src) begin
      if (m_tnew == TNEW_ZERO) begin
        sel = SEL_M;
      end else begin
        sel = SEL_RF;
      end
    end else if (w_wreg == src) begin
      if (w_tnew == TNEW_ZERO) begin
        sel = SEL_W;
      end else begin
        sel = SEL_RF;
      end
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Same-cycle stall decision and forwarding selects for the D instruction.
  always_comb begin
    hz_rs_s   = 1'b0;
    hz_rt_s   = 1'b0;
    stall_s   = 1'b0;
    fwd_rd1_s = SEL_RF;
    fwd_rd2_s = SEL_RF;
    hz_rs_s   = hazard(bus.D_Rs, bus.D_TuseRs, e_wreg_r, e_tnew_r,
                       m_wreg_r, m_tnew_r);
    hz_rt_s   = hazard(bus.D_Rt, bus.D_TuseRt, e_wreg_r, e_tnew_r,
                       m_wreg_r, m_tnew_r);
    stall_s   = hz_rs_s | hz_rt_s;
    fwd_rd1_s = fwd_sel(bus.D_Rs, e_wreg_r, e_tnew_r, m_wreg_r, m_tnew_r,
                        w_wreg_r, w_tnew_r);
    fwd_rd2_s = fwd_sel(bus.D_Rt, e_wreg_r, e_tnew_r, m_wreg_r, m_tnew_r,
                        w_wreg_r, w_tnew_r);
  end

  // Slot advance: E takes the D instruction or a bubble on stall, M and W
  // inherit the older slot with its Tnew counted down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_wreg_r <= REG_ZERO;
      e_tnew_r <= TNEW_ZERO;
      m_wreg_r <= REG_ZERO;
      m_tnew_r <= TNEW_ZERO;
      w_wreg_r <= REG_ZERO;
      w_tnew_r <= TNEW_ZERO;
    end else begin
      m_wreg_r <= e_wreg_r;
      m_tnew_r <= sat_dec(e_tnew_r);
      w_wreg_r <= m_wreg_r;
      w_tnew_r <= sat_dec(m_tnew_r);
      if (stall_s) begin
        e_wreg_r <= REG_ZERO;
        e_tnew_r <= TNEW_ZERO;
      end else begin
        e_wreg_r <= bus.D_WriteReg;
        e_tnew_r <= bus.D_Tnew;
      end
    end
  end

  // Saturating count of stall cycles since reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.FwdRd1Sel   = fwd_rd1_s;
  assign bus.FwdRd2Sel   = fwd_rd2_s;
  assign bus.take_branch = bus.cmp_Branch & ~stall_s;
  assign bus.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: drives D-stage instruction
// sequences and compares the stall/forward outputs with hand-derived values.
module tb_branch_hazard_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  branch_hazard_ctrl_if #(.REG_W(5), .T_W(2), .CNT_W(16)) bus ();

  branch_hazard_ctrl #(.REG_W(5), .T_W(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rs, input int tuse_rs, input int rt,
                       input int tuse_rt, input int wreg, input int tnew,
                       input int br);
    bus.D_Rs       = 5'(rs);
    bus.D_TuseRs   = 2'(tuse_rs);
    bus.D_Rt       = 5'(rt);
    bus.D_TuseRt   = 2'(tuse_rt);
    bus.D_WriteReg = 5'(wreg);
    bus.D_Tnew     = 2'(tnew);
    bus.cmp_Branch = br[0];
    #2;
  endtask

  task automatic idle_cycle();
    drive(0, 3, 0, 3, 0, 0, 0);
    tick();
  endtask

  // Directed stimulus sequence.
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(int'($urandom_range(31, 1)), int'($urandom_range(3, 0)),
          int'($urandom_range(31, 1)), int'($urandom_range(3, 0)),
          int'($urandom_range(31, 1)), int'($urandom_range(2, 0)), 1);
    tick();
    tick();
    check_val("rst_stall", int'(bus.stall), 0);
    check_val("rst_fwd1", int'(bus.FwdRd1Sel), 0);
    check_val("rst_fwd2", int'(bus.FwdRd2Sel), 0);
    check_val("rst_cnt", int'(bus.stall_cnt), 0);
    check_val("rst_take", int'(bus.take_branch), 1);

    reset = 1'b1;
    drive(5, 0, 0, 3, 0, 0, 0);
    check_val("rel_stall", int'(bus.stall), 0);
    tick();

    // ALU producer followed by beq on its result.
    drive(0, 3, 0, 3, 8, 1, 0);
    check_val("alu_prod_stall", int'(bus.stall), 0);
    tick();
    drive(8, 0, 0, 3, 0, 0, 1);
    check_val("alu_stall", int'(bus.stall), 1);
    check_val("alu_take0", int'(bus.take_branch), 0);
    check_val("alu_fwd_blk", int'(bus.FwdRd1Sel), 0);
    tick();
    check_val("alu_go", int'(bus.stall), 0);
    check_val("alu_fwd_m", int'(bus.FwdRd1Sel), 1);
    check_val("alu_take1", int'(bus.take_branch), 1);
    check_val("alu_cnt", int'(bus.stall_cnt), 1);
    tick();

    // Load producer followed by beq on rt: two stall cycles.
    drive(0, 3, 0, 3, 9, 2, 0);
    tick();
    drive(0, 3, 9, 0, 0, 0, 1);
    check_val("ld_stall1", int'(bus.stall), 1);
    check_val("ld_take0", int'(bus.take_branch), 0);
    tick();
    check_val("ld_stall2", int'(bus.stall), 1);
    check_val("ld_fwd_blk", int'(bus.FwdRd2Sel), 0);
    tick();
    check_val("ld_go", int'(bus.stall), 0);
    check_val("ld_fwd_w", int'(bus.FwdRd2Sel), 2);
    check_val("ld_take1", int'(bus.take_branch), 1);
    check_val("ld_cnt", int'(bus.stall_cnt), 3);
    tick();

    // Producer targeting $0 never stalls or forwards.
    drive(0, 3, 0, 3, 0, 2, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check_val("r0_stall", int'(bus.stall), 0);
    check_val("r0_fwd1", int'(bus.FwdRd1Sel), 0);
    check_val("r0_take", int'(bus.take_branch), 1);
    tick();

    // Tuse boundaries against a load in E (Tnew=2).
    drive(0, 3, 0, 3, 11, 2, 0);
    tick();
    drive(11, 3, 0, 3, 0, 0, 1);
    check_val("nouse_stall", int'(bus.stall), 0);
    check_val("nouse_fwd_blk", int'(bus.FwdRd1Sel), 0);
    drive(0, 3, 11, 2, 0, 0, 1);
    check_val("tuse2_stall", int'(bus.stall), 0);
    drive(0, 3, 11, 1, 0, 0, 1);
    check_val("tuse1_stall", int'(bus.stall), 1);
    check_val("tuse1_take", int'(bus.take_branch), 0);
    idle_cycle();
    check_val("tuse_cnt", int'(bus.stall_cnt), 3);

    // Not-ready M match must not fall through to a ready W copy.
    drive(0, 3, 0, 3, 12, 1, 0);
    tick();
    drive(0, 3, 0, 3, 12, 2, 0);
    tick();
    idle_cycle();
    drive(12, 2, 0, 3, 0, 0, 0);
    check_val("mblk_stall", int'(bus.stall), 0);
    check_val("mblk_fwd1", int'(bus.FwdRd1Sel), 0);
    tick();
    idle_cycle();

    // Two ALU writes to $10 back to back: newest (M) wins.
    drive(0, 3, 0, 3, 10, 1, 0);
    tick();
    drive(0, 3, 0, 3, 10, 1, 0);
    tick();
    drive(10, 0, 0, 3, 0, 0, 1);
    check_val("new_stall", int'(bus.stall), 1);
    check_val("new_fwd_blk", int'(bus.FwdRd1Sel), 0);
    tick();
    check_val("new_go", int'(bus.stall), 0);
    check_val("new_fwd_m", int'(bus.FwdRd1Sel), 1);
    check_val("new_take", int'(bus.take_branch), 1);
    check_val("new_cnt", int'(bus.stall_cnt), 4);
    tick();
    idle_cycle();

    // Reset asserted during the second load-stall cycle.
    drive(0, 3, 0, 3, 9, 2, 0);
    tick();
    drive(0, 3, 9, 0, 0, 0, 1);
    check_val("mid_stall1", int'(bus.stall), 1);
    tick();
    check_val("mid_stall2", int'(bus.stall), 1);
    check_val("mid_cnt_pre", int'(bus.stall_cnt), 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    check_val("mid_stall_rst", int'(bus.stall), 0);
    check_val("mid_fwd2_rst", int'(bus.FwdRd2Sel), 0);
    check_val("mid_cnt_rst", int'(bus.stall_cnt), 0);
    check_val("mid_take_rst", int'(bus.take_branch), 1);
    tick();
    check_val("mid_cnt_after", int'(bus.stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
